adsr_envelope_poly: RTL and testbench

- Parametrised, polyphonic successor to the single-voice ADSR envelope generator.
- Produces one ENV_BITS-wide ADSR envelope per voice. Voices are time-multiplexed through one datapath, one voice per clk cycle, on each sample tick.
- Sits between the per-voice gate/parameter registers and the per-voice tone modulators. Amplitudes are streamed out tagged with a voice index.
- Adds behaviour the single-voice block lacks:
  - click-free retrigger: attack starts from the current level;
  - release starts from the actual current level, not the sustain level;
  - sample-tick overrun detection.

---
 rtl/adsr_pkg.sv | 57 +++++
 rtl/adsr_rate_table.sv | 26 ++
 rtl/adsr_envelope_poly.sv | 211 +++++++++++++++++++++
 tb/tb_adsr_envelope_poly.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adsr_pkg.sv
// rtl/adsr_pkg.sv - states, rate time tables and helper functions shared by the ADSR envelope blocks
package adsr_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_e;

  localparam logic MODE_ATTACK        = 1'b0;
  localparam logic MODE_DECAY_RELEASE = 1'b1;
  localparam int   DR_TIME_SCALE      = 3;

  function automatic real attack_time(input int code);
    real t;
    case (code)
      0:       t = 0.002;
      1:       t = 0.008;
      2:       t = 0.016;
      3:       t = 0.024;
      4:       t = 0.038;
      5:       t = 0.056;
      6:       t = 0.068;
      7:       t = 0.080;
      8:       t = 0.1;
      9:       t = 0.25;
      10:      t = 0.5;
      11:      t = 0.8;
      12:      t = 1.0;
      13:      t = 3.0;
      14:      t = 5.0;
      default: t = 8.0;
    endcase
    return t;
  endfunction

  // Accumulator step that spans the full 2^acc_bits range in t_s seconds of sample ticks.
  function automatic longint rate_inc(input real t_s, input int acc_bits, input int fs);
    return longint'($rtoi((2.0 ** acc_bits) / (t_s * real'(fs))));
  endfunction

  function automatic logic [15:0] sus_level(input logic [3:0] s_code, input int env_bits);
    logic [15:0] rep;
    rep = {4{s_code}};
    return rep >> (16 - env_bits);
  endfunction

  // Concave curve: steep at first, flattening out; maps 0->0 and max->max.
  function automatic int exp_point(input int x, input int env_bits);
    real m;
    m = (2.0 ** env_bits) - 1.0;
    return $rtoi(m * (1.0 - $exp(-4.0 * real'(x) / m)) / (1.0 - $exp(-4.0)) + 0.5);
  endfunction

endpackage

// File: rtl/adsr_rate_table.sv
// rtl/adsr_rate_table.sv - maps a 4-bit rate code and mode to a phase accumulator increment
module adsr_rate_table #(
  parameter int ACC_BITS        = 26,
  parameter int SAMPLE_CLK_FREQ = 44100
) (
  input  logic [3:0]          code_i,
  input  logic                mode_i,
  output logic [ACC_BITS-1:0] inc_o
);
  import adsr_pkg::*;

  logic [ACC_BITS-1:0] inc_a_tab  [16];
  logic [ACC_BITS-1:0] inc_dr_tab [16];

  for (genvar c = 0; c < 16; c++) begin : g_tab
    localparam logic [ACC_BITS-1:0] INC_A =
      ACC_BITS'(rate_inc(attack_time(c), ACC_BITS, SAMPLE_CLK_FREQ));
    localparam logic [ACC_BITS-1:0] INC_DR =
      ACC_BITS'(rate_inc(attack_time(c) * real'(DR_TIME_SCALE), ACC_BITS, SAMPLE_CLK_FREQ));
    assign inc_a_tab[c]  = INC_A;
    assign inc_dr_tab[c] = INC_DR;
  end

  assign inc_o = (mode_i == MODE_ATTACK) ? inc_a_tab[code_i] : inc_dr_tab[code_i];

endmodule

// File: rtl/adsr_envelope_poly.sv
// rtl/adsr_envelope_poly.sv - time-multiplexed polyphonic ADSR envelope; ADSR_EXP_CURVE_EN selects exponential decay/release
module adsr_envelope_poly #(
  parameter int NUM_VOICES      = 4,
  parameter int ENV_BITS        = 8,
  parameter int ACC_BITS        = 26,
  parameter int SAMPLE_CLK_FREQ = 44100
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                sample_en,
  input  logic [NUM_VOICES-1:0]                               gate,
  input  logic [4*NUM_VOICES-1:0]                             a,
  input  logic [4*NUM_VOICES-1:0]                             d,
  input  logic [4*NUM_VOICES-1:0]                             s,
  input  logic [4*NUM_VOICES-1:0]                             r,
  output logic                                                env_valid,
  output logic [$clog2((NUM_VOICES > 1) ? NUM_VOICES : 2)-1:0] env_voice,
  output logic [ENV_BITS-1:0]                                 env_amplitude,
  output logic [NUM_VOICES-1:0]                               env_active,
  output logic                                                overrun
);
  import adsr_pkg::*;

  localparam int VW    = $clog2((NUM_VOICES > 1) ? NUM_VOICES : 2);
  localparam int SHIFT = ACC_BITS - ENV_BITS;
  localparam logic [ENV_BITS-1:0] MAX_AMP = '1;

  adsr_state_e           state_q [NUM_VOICES];
  logic [ACC_BITS:0]     acc_q   [NUM_VOICES];
  logic [ENV_BITS-1:0]   amp_q   [NUM_VOICES];
  logic [ENV_BITS-1:0]   rel_q   [NUM_VOICES];
  logic [NUM_VOICES-1:0] prev_gate_q;
  logic                  busy_q;
  logic [VW-1:0]         slot_q;
  logic                  env_valid_q;
  logic [VW-1:0]         env_voice_q;
  logic [ENV_BITS-1:0]   env_amp_q;
  logic                  overrun_q;

  logic          start, proc;
  logic [VW-1:0] cur;

  assign start = sample_en & ~busy_q;
  assign proc  = start | busy_q;
  assign cur   = busy_q ? slot_q : '0;

  adsr_state_e         cur_state;
  logic [ACC_BITS:0]   cur_acc;
  logic [ENV_BITS-1:0] cur_amp, cur_rel;
  logic                cur_gate, cur_pg;
  logic [3:0]          a_n, d_n, s_n, r_n;

  always_comb begin
    cur_state = ST_OFF;
    cur_acc   = '0;
    cur_amp   = '0;
    cur_rel   = '0;
    cur_gate  = 1'b0;
    cur_pg    = 1'b0;
    a_n       = '0;
    d_n       = '0;
    s_n       = '0;
    r_n       = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (cur == VW'(i)) begin
        cur_state = state_q[i];
        cur_acc   = acc_q[i];
        cur_amp   = amp_q[i];
        cur_rel   = rel_q[i];
        cur_gate  = gate[i];
        cur_pg    = prev_gate_q[i];
        a_n       = a[4*i +: 4];
        d_n       = d[4*i +: 4];
        s_n       = s[4*i +: 4];
        r_n       = r[4*i +: 4];
      end
    end
  end

  // One shared rate lookup: only the active state's code matters in a slot.
  logic [3:0]          rate_code;
  logic                rate_mode;
  logic [ACC_BITS-1:0] inc;

  assign rate_mode = (cur_state == ST_ATTACK) ? MODE_ATTACK : MODE_DECAY_RELEASE;
  assign rate_code = (cur_state == ST_ATTACK) ? a_n :
                     (cur_state == ST_DECAY)  ? d_n : r_n;

  adsr_rate_table #(
    .ACC_BITS        (ACC_BITS),
    .SAMPLE_CLK_FREQ (SAMPLE_CLK_FREQ)
  ) u_rate (
    .code_i (rate_code),
    .mode_i (rate_mode),
    .inc_o  (inc)
  );

  logic [ENV_BITS-1:0] sus, top, curve;

  assign sus = ENV_BITS'(sus_level(s_n, ENV_BITS));
  assign top = cur_acc[ACC_BITS-1 -: ENV_BITS];

`ifdef ADSR_EXP_CURVE_EN
  logic [ENV_BITS-1:0] exp_tab [2**ENV_BITS];
  for (genvar k = 0; k < 2**ENV_BITS; k++) begin : g_exp
    localparam logic [ENV_BITS-1:0] EXP_K = ENV_BITS'(exp_point(k, ENV_BITS));
    assign exp_tab[k] = EXP_K;
  end
  assign curve = exp_tab[top];
`else
  assign curve = top;
`endif

  logic [2*ENV_BITS-1:0] dec_prod, rel_prod;
  logic [ENV_BITS-1:0]   dec_amp, rel_amp;

  assign dec_prod = {{ENV_BITS{1'b0}}, MAX_AMP - sus} * {{ENV_BITS{1'b0}}, curve};
  assign rel_prod = {{ENV_BITS{1'b0}}, cur_rel} * {{ENV_BITS{1'b0}}, curve};
  assign dec_amp  = MAX_AMP - dec_prod[2*ENV_BITS-1 -: ENV_BITS];
  assign rel_amp  = cur_rel - rel_prod[2*ENV_BITS-1 -: ENV_BITS];

  adsr_state_e         nx_state;
  logic [ACC_BITS:0]   nx_acc;
  logic [ENV_BITS-1:0] nx_amp, nx_rel;
  logic                rise, fall, ovf;

  assign rise = cur_gate & ~cur_pg;
  assign fall = ~cur_gate & cur_pg;
  assign ovf  = cur_acc[ACC_BITS];

  always_comb begin
    nx_state = cur_state;
    nx_acc   = cur_acc;
    nx_amp   = cur_amp;
    nx_rel   = cur_rel;
    if (rise) begin
      nx_state = ST_ATTACK;
      nx_acc   = {1'b0, cur_amp, {SHIFT{1'b0}}};
    end else if (fall && (cur_state inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
      nx_state = ST_RELEASE;
      nx_rel   = cur_amp;
      nx_acc   = '0;
    end else if (ovf && (cur_state inside {ST_ATTACK, ST_DECAY, ST_RELEASE})) begin
      nx_acc = '0;
      case (cur_state)
        ST_ATTACK: begin nx_state = ST_DECAY;   nx_amp = MAX_AMP; end
        ST_DECAY:  begin nx_state = ST_SUSTAIN; nx_amp = sus;     end
        default:   begin nx_state = ST_OFF;     nx_amp = '0;      end
      endcase
    end else begin
      case (cur_state)
        ST_ATTACK:  begin nx_acc = cur_acc + {1'b0, inc}; nx_amp = top;     end
        ST_DECAY:   begin nx_acc = cur_acc + {1'b0, inc}; nx_amp = dec_amp; end
        ST_SUSTAIN: nx_amp = sus;
        ST_RELEASE: begin nx_acc = cur_acc + {1'b0, inc}; nx_amp = rel_amp; end
        default:    nx_amp = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        state_q[i] <= ST_OFF;
        acc_q[i]   <= '0;
        amp_q[i]   <= '0;
        rel_q[i]   <= '0;
      end
      prev_gate_q <= '0;
      busy_q      <= 1'b0;
      slot_q      <= '0;
      env_valid_q <= 1'b0;
      env_voice_q <= '0;
      env_amp_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      env_valid_q <= proc;
      if (proc) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (cur == VW'(i)) begin
            state_q[i]     <= nx_state;
            acc_q[i]       <= nx_acc;
            amp_q[i]       <= nx_amp;
            rel_q[i]       <= nx_rel;
            prev_gate_q[i] <= cur_gate;
          end
        end
        env_voice_q <= cur;
        env_amp_q   <= nx_amp;
        if (cur == VW'(NUM_VOICES - 1)) begin
          busy_q <= 1'b0;
        end else begin
          busy_q <= 1'b1;
          slot_q <= cur + VW'(1);
        end
      end
      if (sample_en && busy_q) overrun_q <= 1'b1;
    end
  end

  always_comb begin
    env_active = '0;
    for (int i = 0; i < NUM_VOICES; i++) env_active[i] = (state_q[i] != ST_OFF);
  end

  assign env_valid     = env_valid_q;
  assign env_voice     = env_voice_q;
  assign env_amplitude = env_amp_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_adsr_envelope_poly.sv
// tb/tb_adsr_envelope_poly.sv - self-checking bench for adsr_envelope_poly against a behavioural envelope model
module tb_adsr_envelope_poly;
  localparam int NV   = 4;
  localparam int EB   = 8;
  localparam int AB   = 26;
  localparam int FS   = 44100;
  localparam int MAXV = 255;
  localparam int M_OFF = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en = 1'b0;
  logic [3:0]  gate = '0;
  logic [15:0] a = '0, d = '0, s = 16'h8888, r = '0;
  logic        env_valid;
  logic [1:0]  env_voice;
  logic [7:0]  env_amplitude;
  logic [3:0]  env_active;
  logic        overrun;

  always #5 clk = ~clk;

  adsr_envelope_poly #(
    .NUM_VOICES (NV), .ENV_BITS (EB), .ACC_BITS (AB), .SAMPLE_CLK_FREQ (FS)
  ) dut (
    .clk (clk), .rst (rst), .sample_en (sample_en), .gate (gate),
    .a (a), .d (d), .s (s), .r (r),
    .env_valid (env_valid), .env_voice (env_voice), .env_amplitude (env_amplitude),
    .env_active (env_active), .overrun (overrun)
  );

  int errors = 0;
  int checks = 0;

  real atk_t [16] = '{0.002, 0.008, 0.016, 0.024, 0.038, 0.056, 0.068, 0.080,
                      0.1, 0.25, 0.5, 0.8, 1.0, 3.0, 5.0, 8.0};

  int     m_st  [NV];
  longint m_acc [NV];
  int     m_amp [NV];
  int     m_rel [NV];
  bit     m_pg  [NV];
  int     obs_amp [NV];

  function automatic int inc_of(int code, bit dr);
    real t;
    t = atk_t[code] * (dr ? 3.0 : 1.0);
    return $rtoi((2.0 ** AB) / (t * FS));
  endfunction

  function automatic int nib(logic [15:0] v, int i);
    return int'(v[4*i +: 4]);
  endfunction

  function automatic logic [3:0] model_active();
    logic [3:0] res;
    for (int v = 0; v < NV; v++) res[v] = (m_st[v] != M_OFF);
    return res;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_st[v] = M_OFF; m_acc[v] = 0; m_amp[v] = 0; m_rel[v] = 0; m_pg[v] = 0;
    end
  endtask

  // One sample-tick update of voice v, straight from the envelope rules.
  task automatic model_voice(int v);
    bit g;
    int sus, top;
    longint full, unit;
    g    = gate[v];
    sus  = nib(s, v) * 17;
    full = longint'(1) << AB;
    unit = longint'(1) << (AB - EB);
    top  = int'((m_acc[v] / unit) % 256);
    if (g && !m_pg[v]) begin
      m_st[v]  = M_ATT;
      m_acc[v] = longint'(m_amp[v]) * unit;
    end else if (!g && m_pg[v] && (m_st[v] inside {M_ATT, M_DEC, M_SUS})) begin
      m_st[v]  = M_REL;
      m_rel[v] = m_amp[v];
      m_acc[v] = 0;
    end else if (m_acc[v] >= full && (m_st[v] inside {M_ATT, M_DEC, M_REL})) begin
      m_acc[v] = 0;
      if (m_st[v] == M_ATT)      begin m_st[v] = M_DEC; m_amp[v] = MAXV; end
      else if (m_st[v] == M_DEC) begin m_st[v] = M_SUS; m_amp[v] = sus;  end
      else                       begin m_st[v] = M_OFF; m_amp[v] = 0;    end
    end else begin
      case (m_st[v])
        M_ATT: begin m_amp[v] = top; m_acc[v] += inc_of(nib(a, v), 1'b0); end
        M_DEC: begin m_amp[v] = MAXV - ((MAXV - sus) * top) / 256; m_acc[v] += inc_of(nib(d, v), 1'b1); end
        M_SUS: m_amp[v] = sus;
        M_REL: begin m_amp[v] = m_rel[v] - (m_rel[v] * top) / 256; m_acc[v] += inc_of(nib(r, v), 1'b1); end
        default: m_amp[v] = 0;
      endcase
    end
    m_pg[v] = g;
  endtask

  task automatic do_tick();
    @(negedge clk); sample_en = 1'b1;
    @(negedge clk); sample_en = 1'b0;
    for (int v = 0; v < NV; v++) model_voice(v);
    for (int v = 0; v < NV; v++) begin
      checks++;
      if (env_valid !== 1'b1 || env_voice !== 2'(v)) begin
        errors++;
        $display("FAIL sweep_slot: valid=%0b voice=%0d, expected valid=1 voice=%0d", env_valid, env_voice, v);
      end
      checks++;
      if (env_amplitude !== 8'(m_amp[v])) begin
        errors++;
        $display("FAIL amplitude v%0d: got %0h expected %0h", v, env_amplitude, m_amp[v]);
      end
      obs_amp[v] = int'(env_amplitude);
      @(negedge clk);
    end
    checks++;
    if (env_valid !== 1'b0) begin
      errors++;
      $display("FAIL sweep_end: env_valid=%0b expected 0", env_valid);
    end
    checks++;
    if (env_active !== model_active()) begin
      errors++;
      $display("FAIL env_active: got %b expected %b", env_active, model_active());
    end
  endtask

  task automatic check_zero_outputs(string tag);
    checks++; if (env_valid !== 1'b0) begin errors++; $display("FAIL %s env_valid: got %b expected 0", tag, env_valid); end
    checks++; if (env_voice !== 2'd0) begin errors++; $display("FAIL %s env_voice: got %0d expected 0", tag, env_voice); end
    checks++; if (env_amplitude !== 8'd0) begin errors++; $display("FAIL %s env_amplitude: got %0h expected 0", tag, env_amplitude); end
    checks++; if (env_active !== 4'd0) begin errors++; $display("FAIL %s env_active: got %b expected 0", tag, env_active); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL %s overrun: got %b expected 0", tag, overrun); end
  endtask

  task automatic test_reset(string tag);
    rst = 1'b1; sample_en = 1'b0; gate = '0;
    a = '0; d = '0; r = '0; s = 16'h8888;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs(tag);
    model_reset();
  endtask

  task automatic test_attack();
    int first_ff;
    first_ff = -1;
    gate = 4'b0001;
    for (int k = 0; k < 92; k++) begin
      do_tick();
      if (first_ff < 0 && obs_amp[0] == 255) first_ff = k;
    end
    checks++;
    if (first_ff != 89) begin errors++; $display("FAIL attack_peak_tick: got %0d expected 89", first_ff); end
    checks++;
    if (env_active !== 4'b0001) begin errors++; $display("FAIL attack_active: got %b expected 0001", env_active); end
  endtask

  task automatic test_decay_sustain();
    int n;
    n = 0;
    while (m_st[0] != M_SUS && n < 400) begin do_tick(); n++; end
    checks++;
    if (m_st[0] != M_SUS) begin errors++; $display("FAIL decay_timeout: ticks=%0d limit=400", n); end
    repeat (4) do_tick();
    checks++;
    if (obs_amp[0] != 'h88) begin errors++; $display("FAIL sustain_level: got %0h expected 88", obs_amp[0]); end
    s[3:0] = 4'hC;
    do_tick();
    checks++;
    if (obs_amp[0] != 'hCC) begin errors++; $display("FAIL sustain_live: got %0h expected cc", obs_amp[0]); end
    s[3:0] = 4'h8;
    do_tick();
  endtask

  task automatic test_release();
    int n, prev;
    bit mono_ok;
    n = 0; mono_ok = 1; prev = obs_amp[0];
    gate = 4'b0000;
    while (m_st[0] != M_OFF && n < 400) begin
      do_tick(); n++;
      if (obs_amp[0] > prev) mono_ok = 0;
      prev = obs_amp[0];
    end
    checks++;
    if (m_st[0] != M_OFF) begin errors++; $display("FAIL release_timeout: ticks=%0d limit=400", n); end
    checks++;
    if (!mono_ok) begin errors++; $display("FAIL release_monotonic: rising step seen, expected non-increasing"); end
    checks++;
    if (obs_amp[0] != 0 || env_active !== 4'b0000) begin
      errors++; $display("FAIL release_end: amp=%0h active=%b expected 0 and 0000", obs_amp[0], env_active);
    end
  endtask

  task automatic test_retrigger();
    int n, prev;
    gate = 4'b0001;
    repeat (100) do_tick();
    gate = 4'b0000;
    n = 0;
    while (m_amp[0] > 'h40 && n < 400) begin do_tick(); n++; end
    prev = obs_amp[0];
    gate = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      do_tick();
      checks++;
      if (obs_amp[0] < prev || obs_amp[0] == 0) begin
        errors++; $display("FAIL retrigger_k%0d: got %0h expected >= %0h and nonzero", k, obs_amp[0], prev);
      end
    end
  endtask

  task automatic test_independence();
    test_reset("reset_indep");
    gate = 4'b0100;
    repeat (20) do_tick();
    checks++;
    if (env_active !== 4'b0100) begin errors++; $display("FAIL indep_active: got %b expected 0100", env_active); end
    checks++;
    if (obs_amp[0] != 0 || obs_amp[1] != 0 || obs_amp[3] != 0) begin
      errors++; $display("FAIL indep_idle: v0=%0h v1=%0h v3=%0h expected 0", obs_amp[0], obs_amp[1], obs_amp[3]);
    end
    checks++;
    if (obs_amp[2] == 0) begin errors++; $display("FAIL indep_v2: got 0 expected rising level"); end
  endtask

  task automatic test_overrun();
    int cnt;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b expected 0", overrun); end
    @(negedge clk); sample_en = 1'b1;
    @(negedge clk); sample_en = 1'b0;
    for (int v = 0; v < NV; v++) model_voice(v);
    cnt = 0;
    for (int j = 0; j < 10; j++) begin
      if (env_valid === 1'b1) begin
        cnt++;
        checks++;
        if (env_amplitude !== 8'(m_amp[env_voice])) begin
          errors++; $display("FAIL overrun_amp v%0d: got %0h expected %0h", env_voice, env_amplitude, m_amp[env_voice]);
        end
      end
      sample_en = (j == 1);
      @(negedge clk);
    end
    checks++;
    if (cnt != NV) begin errors++; $display("FAIL overrun_valid_count: got %0d expected %0d", cnt, NV); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", overrun); end
    repeat (2) do_tick();
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_reset_mid_attack();
    gate = 4'b0001;
    repeat (30) do_tick();
    @(negedge clk); sample_en = 1'b1;
    @(negedge clk); sample_en = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_zero_outputs("mid_reset");
    @(negedge clk);
    checks++;
    if (env_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_abort: env_valid=%b expected 0", env_valid); end
    model_reset();
    do_tick();
    checks++;
    if (obs_amp[0] != 0 || env_active[0] !== 1'b1) begin
      errors++; $display("FAIL restart_attack: amp=%0h active0=%b expected 0 and 1", obs_amp[0], env_active[0]);
    end
    repeat (5) do_tick();
  endtask

  task automatic test_random();
    test_reset("reset_random");
    for (int v = 0; v < NV; v++) begin
      a[4*v +: 4] = 4'($urandom_range(0, 2));
      d[4*v +: 4] = 4'($urandom_range(0, 1));
      r[4*v +: 4] = 4'($urandom_range(0, 1));
      s[4*v +: 4] = 4'($urandom_range(0, 15));
    end
    for (int k = 0; k < 400; k++) begin
      for (int v = 0; v < NV; v++) begin
        if ($urandom_range(0, 24) == 0) gate[v] = ~gate[v];
        if ($urandom_range(0, 49) == 0) s[4*v +: 4] = 4'($urandom_range(0, 15));
      end
      do_tick();
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset("reset");
    test_attack();
    test_decay_sustain();
    test_release();
    test_retrigger();
    test_independence();
    test_overrun();
    test_reset_mid_attack();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
